// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: paces GAP/SHOW rounds, picks moles from a 3-bit LFSR,
// scores hits and wrong presses, derives the difficulty level and tracks lives.
module mole_round_scheduler #(
    parameter int unsigned GAP_CYCLES = 150000000,
    parameter int unsigned SHOW_L0    = 150000000,
    parameter int unsigned SHOW_L1    = 100000000,
    parameter int unsigned SHOW_L2    = 50000000,
    parameter int unsigned SHOW_L3    = 25000000,
    parameter int unsigned MAX_LIVES  = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       game,
    input  logic [2:0] hit_pulse,
    output logic [2:0] mole,
    output logic [7:0] score,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       round_done
);

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StShow,
        StOver
    } state_e;

    localparam logic [27:0] GapLoad   = 28'(GAP_CYCLES - 1);
    localparam logic [1:0]  LivesInit = 2'(MAX_LIVES);

    state_e      state_q, state_d;
    logic [27:0] timer_q, timer_d;
    logic [2:0]  lfsr_q, lfsr_d;
    logic [2:0]  mole_q, mole_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        game_over_q, game_over_d;
    logic        round_done_q, round_done_d;

    logic [2:0]  lfsr_step;
    logic [1:0]  level_c;

    // XNOR feedback keeps 111 out of the 7-state cycle that starts at 000.
    assign lfsr_step = {lfsr_q[1:0], ~(lfsr_q[2] ^ lfsr_q[1])};

    function automatic logic [2:0] mole_decode(input logic [2:0] v);
        logic [2:0] m;
        case (v)
            3'd1, 3'd5:       m = 3'b001;
            3'd0, 3'd2, 3'd7: m = 3'b010;
            default:          m = 3'b100;
        endcase
        return m;
    endfunction

    function automatic logic [27:0] show_load(input logic [1:0] lvl);
        logic [27:0] t;
        case (lvl)
            2'd0:    t = 28'(SHOW_L0 - 1);
            2'd1:    t = 28'(SHOW_L1 - 1);
            2'd2:    t = 28'(SHOW_L2 - 1);
            default: t = 28'(SHOW_L3 - 1);
        endcase
        return t;
    endfunction

    always_comb begin
        level_c = 2'd0;
        if (score_q >= 8'd11) begin
            level_c = 2'd3;
        end else if (score_q >= 8'd6) begin
            level_c = 2'd2;
        end else if (score_q >= 8'd3) begin
            level_c = 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        lfsr_d       = lfsr_q;
        mole_d       = mole_q;
        score_d      = score_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        round_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                mole_d      = 3'b000;
                game_over_d = 1'b0;
                if (game) begin
                    state_d = StGap;
                    timer_d = GapLoad;
                    score_d = 8'd0;
                    lives_d = LivesInit;
                    lfsr_d  = 3'b000;
                end
            end

            StGap: begin
                if (!game) begin
                    state_d     = StIdle;
                    mole_d      = 3'b000;
                    game_over_d = 1'b0;
                end else if (timer_q == 28'd0) begin
                    state_d = StShow;
                    lfsr_d  = lfsr_step;
                    mole_d  = mole_decode(lfsr_step);
                    timer_d = show_load(level_c);
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end

            StShow: begin
                if (!game) begin
                    state_d     = StIdle;
                    mole_d      = 3'b000;
                    game_over_d = 1'b0;
                end else if ((hit_pulse & mole_q) != 3'b000) begin
                    if (score_q != 8'd255) begin
                        score_d = score_q + 8'd1;
                    end
                    mole_d       = 3'b000;
                    round_done_d = 1'b1;
                    state_d      = StGap;
                    timer_d      = GapLoad;
                end else if (hit_pulse != 3'b000) begin
                    // Wrong press: penalise but leave the round and its timer untouched.
                    if (score_q != 8'd0) begin
                        score_d = score_q - 8'd1;
                    end
                end else if (timer_q == 28'd0) begin
                    lives_d      = lives_q - 2'd1;
                    mole_d       = 3'b000;
                    round_done_d = 1'b1;
                    if (lives_q == 2'd1) begin
                        state_d     = StOver;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = StGap;
                        timer_d = GapLoad;
                    end
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end

            StOver: begin
                mole_d      = 3'b000;
                game_over_d = 1'b1;
                if (!game) begin
                    state_d     = StIdle;
                    game_over_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                mole_d  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            timer_q      <= 28'd0;
            lfsr_q       <= 3'b000;
            mole_q       <= 3'b000;
            score_q      <= 8'd0;
            lives_q      <= LivesInit;
            game_over_q  <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lfsr_q       <= lfsr_d;
            mole_q       <= mole_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
            round_done_q <= round_done_d;
        end
    end

    assign mole       = mole_q;
    assign score      = score_q;
    assign level      = level_c;
    assign lives      = lives_q;
    assign game_over  = game_over_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: scenario tasks plus randomized games checked against
// a round-level model (mole sequence table, window length per score band, lives count).
module tb_mole_round_scheduler;

    localparam int GAP = 4;
    localparam int MAXL = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       game = 1'b0;
    logic [2:0] hit_pulse = 3'b000;
    logic [2:0] mole;
    logic [7:0] score;
    logic [1:0] level;
    logic [1:0] lives;
    logic       game_over;
    logic       round_done;

    int n_checks = 0;
    int n_pass = 0;

    int m_score;
    int m_lives;
    int m_round;

    logic [2:0] mole_seq [7] = '{3'b001, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010};

    mole_round_scheduler #(
        .GAP_CYCLES(4),
        .SHOW_L0   (8),
        .SHOW_L1   (6),
        .SHOW_L2   (4),
        .SHOW_L3   (2),
        .MAX_LIVES (3)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .game      (game),
        .hit_pulse (hit_pulse),
        .mole      (mole),
        .score     (score),
        .level     (level),
        .lives     (lives),
        .game_over (game_over),
        .round_done(round_done)
    );

    always #5 clock = ~clock;

    function automatic int lvl_of(input int s);
        if (s >= 11) return 3;
        if (s >= 6) return 2;
        if (s >= 3) return 1;
        return 0;
    endfunction

    function automatic int show_len(input int s);
        int t [4] = '{8, 6, 4, 2};
        return t[lvl_of(s)];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        game = 1'b1;
        step();
        m_score = 0;
        m_lives = MAXL;
        m_round = 0;
        n_checks++; if (score !== 8'd0) $display("FAIL start_score: got %0d want 0", score); else n_pass++;
        n_checks++; if (lives !== 2'(MAXL)) $display("FAIL start_lives: got %0d want %0d", lives, MAXL); else n_pass++;
        n_checks++; if (mole !== 3'b000) $display("FAIL start_mole: got %b want 000", mole); else n_pass++;
    endtask

    task automatic stop_game();
        game = 1'b0;
        step();
        n_checks++; if (mole !== 3'b000) $display("FAIL stop_mole: got %b want 000", mole); else n_pass++;
        n_checks++; if (game_over !== 1'b0) $display("FAIL stop_over: got %b want 0", game_over); else n_pass++;
        n_checks++; if (round_done !== 1'b0) $display("FAIL stop_done: got %b want 0", round_done); else n_pass++;
        n_checks++; if (score !== 8'(m_score)) $display("FAIL stop_score: got %0d want %0d", score, m_score); else n_pass++;
    endtask

    // Precondition: just past the edge that entered GAP. Actions:
    // 0 hit at show edge k, 1 timeout, 2 wrong at k then hit at k+1,
    // 3 game off at k, 4 reset at k, 5 wrong at k then timeout.
    task automatic do_round(input int action, input int k);
        logic [2:0] em;
        logic [2:0] wrong;
        int win;
        em = mole_seq[m_round % 7];
        win = show_len(m_score);
        for (int i = 1; i < GAP; i++) begin
            step();
            n_checks++; if (mole !== 3'b000) $display("FAIL gap_mole: got %b want 000", mole); else n_pass++;
            if (i == 1) begin
                n_checks++; if (round_done !== 1'b0) $display("FAIL done_width: got %b want 0", round_done); else n_pass++;
            end
        end
        step();
        n_checks++; if (mole !== em) $display("FAIL show_mole r%0d: got %b want %b", m_round, mole, em); else n_pass++;
        m_round++;
        wrong = ~em & 3'($urandom_range(1, 7));
        if (wrong == 3'b000) wrong = ~em;
        if (action == 1) begin
            for (int i = 1; i < win; i++) begin
                step();
                n_checks++; if (mole !== em) $display("FAIL window_mole: got %b want %b", mole, em); else n_pass++;
            end
        end else begin
            for (int i = 1; i < k; i++) begin
                step();
                n_checks++; if (mole !== em) $display("FAIL window_mole: got %b want %b", mole, em); else n_pass++;
            end
        end
        case (action)
            0: begin
                hit_pulse = em | 3'($urandom_range(0, 7));
                step();
                hit_pulse = 3'b000;
                if (m_score < 255) m_score++;
            end
            2, 5: begin
                hit_pulse = wrong;
                step();
                hit_pulse = 3'b000;
                if (m_score > 0) m_score--;
                n_checks++; if (score !== 8'(m_score)) $display("FAIL wrong_score: got %0d want %0d", score, m_score); else n_pass++;
                n_checks++; if (mole !== em) $display("FAIL wrong_mole: got %b want %b", mole, em); else n_pass++;
                if (action == 2) begin
                    hit_pulse = em;
                    step();
                    hit_pulse = 3'b000;
                    if (m_score < 255) m_score++;
                end else begin
                    for (int i = k + 1; i <= win; i++) begin
                        step();
                        n_checks++; if (mole !== em) $display("FAIL held_mole: got %b want %b", mole, em); else n_pass++;
                    end
                    step();
                    m_lives--;
                end
            end
            1: begin
                step();
                m_lives--;
            end
            3: begin
                game = 1'b0;
                step();
                n_checks++; if (mole !== 3'b000) $display("FAIL off_mole: got %b want 000", mole); else n_pass++;
                n_checks++; if (round_done !== 1'b0) $display("FAIL off_done: got %b want 0", round_done); else n_pass++;
                n_checks++; if (lives !== 2'(m_lives)) $display("FAIL off_lives: got %0d want %0d", lives, m_lives); else n_pass++;
                n_checks++; if (score !== 8'(m_score)) $display("FAIL off_score: got %0d want %0d", score, m_score); else n_pass++;
            end
            default: begin
                resetn = 1'b0;
                step();
                resetn = 1'b1;
                m_score = 0;
                m_lives = MAXL;
                n_checks++; if (mole !== 3'b000) $display("FAIL rst_mole: got %b want 000", mole); else n_pass++;
                n_checks++; if (score !== 8'd0) $display("FAIL rst_score: got %0d want 0", score); else n_pass++;
                n_checks++; if (lives !== 2'(MAXL)) $display("FAIL rst_lives: got %0d want %0d", lives, MAXL); else n_pass++;
                n_checks++; if (game_over !== 1'b0) $display("FAIL rst_over: got %b want 0", game_over); else n_pass++;
                n_checks++; if (round_done !== 1'b0) $display("FAIL rst_done: got %b want 0", round_done); else n_pass++;
                n_checks++; if (level !== 2'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
            end
        endcase
        if (action <= 2 || action == 5) begin
            n_checks++; if (mole !== 3'b000) $display("FAIL end_mole: got %b want 000", mole); else n_pass++;
            n_checks++; if (round_done !== 1'b1) $display("FAIL end_done: got %b want 1", round_done); else n_pass++;
            n_checks++; if (score !== 8'(m_score)) $display("FAIL end_score: got %0d want %0d", score, m_score); else n_pass++;
            n_checks++; if (lives !== 2'(m_lives)) $display("FAIL end_lives: got %0d want %0d", lives, m_lives); else n_pass++;
            n_checks++; if (level !== 2'(lvl_of(m_score))) $display("FAIL end_level: got %0d want %0d", level, lvl_of(m_score)); else n_pass++;
            n_checks++; if (game_over !== (m_lives == 0)) $display("FAIL end_over: got %b want %b", game_over, m_lives == 0); else n_pass++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        game = 1'b0;
        step();
        step();
        resetn = 1'b1;
        n_checks++; if (mole !== 3'b000) $display("FAIL reset_mole: got %b want 000", mole); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d want 0", score); else n_pass++;
        n_checks++; if (lives !== 2'(MAXL)) $display("FAIL reset_lives: got %0d want %0d", lives, MAXL); else n_pass++;
        n_checks++; if (game_over !== 1'b0) $display("FAIL reset_over: got %b want 0", game_over); else n_pass++;
        n_checks++; if (round_done !== 1'b0) $display("FAIL reset_done: got %b want 0", round_done); else n_pass++;
        n_checks++; if (level !== 2'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_first_round();
        start_game();
        do_round(1, 0);
        do_round(0, 1);
        stop_game();
    endtask

    task automatic test_hit_climb();
        start_game();
        for (int r = 0; r < 11; r++) do_round(0, 1);
        n_checks++; if (level !== 2'd3) $display("FAIL climb_level: got %0d want 3", level); else n_pass++;
        do_round(1, 0);
        stop_game();
    endtask

    task automatic test_wrong_press();
        start_game();
        do_round(0, 1);
        do_round(0, 2);
        do_round(2, 1);
        do_round(0, show_len(m_score));
        stop_game();
        start_game();
        do_round(5, 1);
        stop_game();
    endtask

    task automatic test_game_over();
        start_game();
        do_round(0, 3);
        for (int r = 0; r < MAXL; r++) do_round(1, 0);
        for (int i = 0; i < 3; i++) begin
            hit_pulse = 3'b111;
            step();
            hit_pulse = 3'b000;
            step();
            n_checks++; if (score !== 8'(m_score)) $display("FAIL over_score: got %0d want %0d", score, m_score); else n_pass++;
            n_checks++; if (game_over !== 1'b1 || mole !== 3'b000) $display("FAIL over_hold: got %b/%b want 1/000", game_over, mole); else n_pass++;
        end
        stop_game();
    endtask

    task automatic test_game_off_mid_show();
        start_game();
        do_round(1, 0);
        do_round(3, 3);
        start_game();
        do_round(0, 1);
        stop_game();
    endtask

    task automatic test_reset_mid_show();
        start_game();
        for (int r = 0; r < 5; r++) do_round(0, 1);
        do_round(4, 2);
        start_game();
        do_round(1, 0);
        stop_game();
    endtask

    task automatic test_random();
        for (int g = 0; g < 4; g++) begin
            start_game();
            for (int r = 0; r < 30 && m_lives > 0; r++) begin
                int sel;
                int win;
                sel = $urandom_range(0, 9);
                win = show_len(m_score);
                if (sel < 6) do_round(0, $urandom_range(1, win));
                else if (sel < 8) do_round(2, $urandom_range(1, win));
                else if (sel < 9) do_round(5, $urandom_range(1, win));
                else do_round(1, 0);
            end
            stop_game();
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_hit_climb();
        test_wrong_press();
        test_game_over();
        test_game_off_mid_show();
        test_reset_mid_show();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
